pagetable_tlb: RTL and testbench

//   Fully-associative TLB sitting directly upstream of the page-table walker (translate).

---
 rtl/pagetable_tlb.sv | 207 ++++++++++++++++++++
 tb/tb_pagetable_tlb.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pagetable_tlb.sv
// pagetable_tlb: fully-associative Sv39 TLB placed directly upstream of the
// page-table walker. Hits and bypasses answer in one cycle. A miss drives the
// walker, fills an entry using round-robin replacement, then answers with the
// translation or a page fault.
// Optional feature macro: TLB_ASID_EN (tag entries with satp.ASID and compare it).
module pagetable_tlb #(
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_va,
  input  logic [63:0] satp,
  input  logic [1:0]  mmode,
  input  logic        flush,
  output logic        resp_valid,
  output logic [63:0] resp_pa,
  output logic        resp_fault,
  output logic        walk_en,
  output logic [63:0] walk_va,
  input  logic [63:0] walk_pa,
  input  logic        walk_valid,
  input  logic        walk_done
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    RESP
  } state_t;

  state_t state;

  // Entry storage: valid bits carry the reset, tag/data arrays do not need one.
  logic [ENTRIES-1:0] ent_valid;
  logic [26:0]        ent_vpn [ENTRIES];
  logic [43:0]        ent_ppn [ENTRIES];
`ifdef TLB_ASID_EN
  logic [15:0]        ent_asid [ENTRIES];
  logic [15:0]        walk_asid;
  logic [15:0]        req_asid;
`endif

  logic [IDX_W-1:0]   rr;
  logic               kill;

  logic [26:0]        req_vpn;
  logic [26:0]        walk_vpn;
  logic               bypass;
  logic               accept;
  logic [ENTRIES-1:0] lookup_match;
  logic [ENTRIES-1:0] fill_match;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               fill_hit;
  logic [IDX_W-1:0]   fill_hit_idx;
  logic               fill_en;
  logic [IDX_W-1:0]   fill_idx;

  assign req_vpn  = req_va[38:12];
  assign walk_vpn = walk_va[38:12];
  assign bypass   = (satp[63:60] == 4'd0) || (mmode == 2'b11);
  assign accept   = req_valid && req_ready && (state == IDLE);

`ifdef TLB_ASID_EN
  assign req_asid = satp[59:44];
  logic [43:0] unused_satp;
  assign unused_satp = satp[43:0];
`else
  logic [59:0] unused_satp;
  assign unused_satp = satp[59:0];
`endif

  // Per-entry tag compare for the incoming request and for the walk being filled
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      lookup_match[i] = ent_valid[i] && (ent_vpn[i] == req_vpn);
      fill_match[i]   = ent_valid[i] && (ent_vpn[i] == walk_vpn);
`ifdef TLB_ASID_EN
      lookup_match[i] = lookup_match[i] && (ent_asid[i] == req_asid);
      fill_match[i]   = fill_match[i] && (ent_asid[i] == walk_asid);
`endif
    end
  end

  // Encode match vectors into indices; dedup on fill keeps at most one match
  always_comb begin
    hit          = 1'b0;
    hit_idx      = '0;
    fill_hit     = 1'b0;
    fill_hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (lookup_match[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (fill_match[i]) begin
        fill_hit     = 1'b1;
        fill_hit_idx = IDX_W'(i);
      end
    end
  end

  // A successful walk fills unless a flush killed it or arrives this very cycle
  always_comb begin
    fill_en  = (state == WALK) && walk_done && walk_valid && !kill && !flush;
    fill_idx = fill_hit ? fill_hit_idx : rr;
  end

  // Tag and data write for a fill; an existing matching entry is overwritten in place
  always_ff @(posedge clk) begin
    if (fill_en) begin
      ent_vpn[fill_idx] <= walk_vpn;
      ent_ppn[fill_idx] <= walk_pa[55:12];
`ifdef TLB_ASID_EN
      ent_asid[fill_idx] <= walk_asid;
`endif
    end
  end

  // Control FSM with registered handshake, response and walker outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_pa    <= '0;
      resp_fault <= 1'b0;
      walk_en    <= 1'b0;
      walk_va    <= '0;
      kill       <= 1'b0;
      rr         <= '0;
      ent_valid  <= '0;
`ifdef TLB_ASID_EN
      walk_asid  <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;

      if (flush) begin
        ent_valid <= '0;
      end else if (fill_en) begin
        ent_valid[fill_idx] <= 1'b1;
      end

      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          kill      <= 1'b0;
          if (accept) begin
            if (bypass) begin
              resp_valid <= 1'b1;
              resp_pa    <= req_va;
            end else if (hit) begin
              resp_valid <= 1'b1;
              resp_pa    <= {8'b0, ent_ppn[hit_idx], req_va[11:0]};
            end else begin
              walk_va   <= req_va;
`ifdef TLB_ASID_EN
              walk_asid <= req_asid;
`endif
              walk_en   <= 1'b1;
              req_ready <= 1'b0;
              state     <= WALK;
            end
          end
        end

        WALK: begin
          if (flush) begin
            kill <= 1'b1;
          end
          if (walk_done) begin
            walk_en    <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
            if (walk_valid) begin
              resp_pa <= walk_pa;
            end else begin
              resp_pa    <= '0;
              resp_fault <= 1'b1;
            end
            if (fill_en && !fill_hit) begin
              rr <= rr + 1'b1;
            end
          end
        end

        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          walk_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pagetable_tlb.sv
// tb_pagetable_tlb: randomized scoreboard bench for pagetable_tlb.
// The reference model is a FIFO of cached translations with capacity ENTRIES.
// Honors TLB_ASID_EN the same way the design does.
module tb_pagetable_tlb;

  localparam int ENTRIES = 8;
  localparam logic [63:0] SV39 = 64'h8000_0000_0000_0000;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_va;
  logic [63:0] satp;
  logic [1:0]  mmode;
  logic        flush;
  logic        resp_valid;
  logic [63:0] resp_pa;
  logic        resp_fault;
  logic        walk_en;
  logic [63:0] walk_va;
  logic [63:0] walk_pa;
  logic        walk_valid;
  logic        walk_done;

  pagetable_tlb #(.ENTRIES(ENTRIES)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_va     (req_va),
    .satp       (satp),
    .mmode      (mmode),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_pa    (resp_pa),
    .resp_fault (resp_fault),
    .walk_en    (walk_en),
    .walk_va    (walk_va),
    .walk_pa    (walk_pa),
    .walk_valid (walk_valid),
    .walk_done  (walk_done)
  );

  typedef struct {
    logic [63:0] pa;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [26:0] vpn;
    logic [15:0] asid;
    logic [43:0] ppn;
  } ent_t;

  exp_t sb_q[$];
  ent_t model_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int          w_lat = 1;
  bit          w_ok = 1'b1;
  logic [63:0] w_pa = '0;
  logic [63:0] exp_walk_va = '0;
  int          exp_walks = 0;
  int          seen_walks = 0;
  bit          abort_walk = 1'b0;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the design wedges somewhere no bounded wait covers
  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] asid_of(input logic [63:0] s);
`ifdef TLB_ASID_EN
    return s[59:44];
`else
    return 16'h0;
`endif
  endfunction

  function automatic int model_find(input logic [26:0] vpn, input logic [15:0] asid);
    foreach (model_q[i]) begin
      if (model_q[i].vpn == vpn && model_q[i].asid == asid) return i;
    end
    return -1;
  endfunction

  // A fill refreshes an existing translation, otherwise evicts the oldest one when full
  task automatic model_fill(input logic [26:0] vpn, input logic [15:0] asid, input logic [43:0] ppn);
    int   idx;
    ent_t e;
    idx = model_find(vpn, asid);
    if (idx >= 0) begin
      model_q[idx].ppn = ppn;
    end else begin
      if (model_q.size() == ENTRIES) void'(model_q.pop_front());
      e.vpn  = vpn;
      e.asid = asid;
      e.ppn  = ppn;
      model_q.push_back(e);
    end
  endtask

  task automatic waitReady();
    int n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL req_ready_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
  endtask

  // Issue one lookup; lat/ok/pa describe how the walker will answer if it misses
  task automatic applyStimulus(input logic [63:0] va, input logic [63:0] s, input logic [1:0] m,
                               input bit fl, input int lat, input bit ok, input logic [63:0] pa,
                               input bit mid_flush);
    bit          is_bypass;
    bit          is_hit;
    int          idx;
    exp_t        e;
    logic [26:0] vpn;
    logic [15:0] asid;
    vpn  = va[38:12];
    asid = asid_of(s);
    waitReady();
    is_bypass = (s[63:60] == 4'd0) || (m == 2'b11);
    idx       = is_bypass ? -1 : model_find(vpn, asid);
    is_hit    = !is_bypass && (idx >= 0);
    if (is_bypass) begin
      e.pa    = va;
      e.fault = 1'b0;
    end else if (is_hit) begin
      e.pa    = {8'h0, model_q[idx].ppn, va[11:0]};
      e.fault = 1'b0;
    end else begin
      w_lat       = lat;
      w_ok        = ok;
      w_pa        = pa;
      exp_walk_va = va;
      exp_walks++;
      e.pa        = ok ? pa : 64'h0;
      e.fault     = !ok;
    end
    sb_q.push_back(e);
    if (fl || mid_flush) model_q.delete();
    if (!is_bypass && !is_hit && ok && !mid_flush) model_fill(vpn, asid, pa[55:12]);

    req_valid = 1'b1;
    req_va    = va;
    satp      = s;
    mmode     = m;
    flush     = fl;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = mid_flush;
    if (is_bypass || is_hit) begin
      checkOutput("one_cycle_resp", resp_valid, 1'b1);
      checkOutput("no_walk_on_hit", walk_en, 1'b0);
    end else begin
      satp = {$urandom, $urandom};
    end
    if (mid_flush) begin
      @(negedge clk);
      flush = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain: %0d responses outstanding, required 0", sb_q.size());
    end
  endtask

  // Walker model: answers after w_lat cycles of walk_en and checks the handshake
  initial begin
    int en_cycles;
    en_cycles  = 0;
    walk_done  = 1'b0;
    walk_valid = 1'b0;
    walk_pa    = '0;
    forever begin
      @(negedge clk);
      walk_done  = 1'b0;
      walk_valid = 1'b0;
      if (walk_en === 1'b1) begin
        en_cycles++;
        if (en_cycles == 1) begin
          seen_walks++;
          checkOutput("walk_va", walk_va, exp_walk_va);
        end
        if (en_cycles == w_lat) begin
          walk_done  = 1'b1;
          walk_valid = w_ok;
          walk_pa    = w_pa;
        end
      end else if (en_cycles != 0) begin
        if (!abort_walk) checkOutput("walk_en_cycles", en_cycles, w_lat);
        en_cycles = 0;
      end
    end
  end

  // Monitor: every response pulse is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (resp_valid === 1'b1) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_resp: resp_valid=1 pa=0x%0h, required no response", resp_pa);
          end else begin
            e = sb_q.pop_front();
            checkOutput("resp_pa", resp_pa, e.pa);
            checkOutput("resp_fault", resp_fault, e.fault);
          end
        end else begin
          checkOutput("fault_idle_zero", resp_fault, 1'b0);
        end
      end
    end
  end

  // Directed scenarios, randomized traffic, then an asynchronous reset mid-walk
  initial begin
    logic [63:0] va;
    logic [63:0] s;
    logic [1:0]  m;
    logic [26:0] vpn;

    reset     = 1'b0;
    req_valid = 1'b0;
    req_va    = '0;
    satp      = '0;
    mmode     = 2'b00;
    flush     = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", req_ready, 1'b0);
    checkOutput("reset_resp_valid", resp_valid, 1'b0);
    checkOutput("reset_resp_pa", resp_pa, 64'h0);
    checkOutput("reset_resp_fault", resp_fault, 1'b0);
    checkOutput("reset_walk_en", walk_en, 1'b0);
    checkOutput("reset_walk_va", walk_va, 64'h0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", req_ready, 1'b1);

    applyStimulus(64'h8000_1234, 64'h0, 2'b00, 1'b0, 1, 1'b1, 64'h0, 1'b0);
    applyStimulus(64'h4000_0ABC, SV39, 2'b00, 1'b0, 5, 1'b1, 64'h8020_3000, 1'b0);
    applyStimulus(64'h4000_0DEF, SV39, 2'b00, 1'b0, 1, 1'b1, 64'h0, 1'b0);
    applyStimulus(64'h4000_0123, SV39, 2'b11, 1'b0, 1, 1'b1, 64'h0, 1'b0);

    applyStimulus(64'h1234_5678, SV39, 2'b01, 1'b0, 3, 1'b0, 64'hDEAD_BEEF_0000_0000, 1'b0);
    applyStimulus(64'h1234_5678, SV39, 2'b01, 1'b0, 2, 1'b1, 64'h9000_0000, 1'b0);
    applyStimulus(64'h1234_5000, SV39, 2'b01, 1'b0, 1, 1'b1, 64'h0, 1'b0);

    applyStimulus(64'h0, 64'h0, 2'b00, 1'b1, 1, 1'b1, 64'h0, 1'b0);
    for (int k = 1; k <= 9; k++)
      applyStimulus(64'(k) << 12 | 64'h10, SV39, 2'b00, 1'b0, 2, 1'b1,
                    64'hA000_0000 + (64'(k) << 12), 1'b0);
    for (int k = 2; k <= 9; k++)
      applyStimulus(64'(k) << 12 | 64'h20, SV39, 2'b00, 1'b0, 1, 1'b1, 64'h0, 1'b0);
    applyStimulus(64'h0000_1030, SV39, 2'b00, 1'b0, 3, 1'b1, 64'hB000_1000, 1'b0);

    applyStimulus(64'h0000_5040, SV39, 2'b00, 1'b1, 1, 1'b1, 64'h0, 1'b0);
    applyStimulus(64'h0000_5040, SV39, 2'b00, 1'b0, 2, 1'b1, 64'hC000_5000, 1'b0);

    applyStimulus(64'h5555_5000, SV39, 2'b00, 1'b0, 6, 1'b1, 64'hD555_5000, 1'b1);
    applyStimulus(64'h5555_5444, SV39, 2'b00, 1'b0, 4, 1'b1, 64'hE555_5000, 1'b0);
    applyStimulus(64'h5555_5888, SV39, 2'b00, 1'b0, 1, 1'b1, 64'h0, 1'b0);

`ifdef TLB_ASID_EN
    applyStimulus(64'h6000_0100, SV39 | (64'd1 << 44), 2'b00, 1'b0, 2, 1'b1, 64'h1_1000_0000, 1'b0);
    applyStimulus(64'h6000_0200, SV39 | (64'd2 << 44), 2'b00, 1'b0, 3, 1'b1, 64'h2_2000_0000, 1'b0);
    applyStimulus(64'h6000_0300, SV39 | (64'd1 << 44), 2'b00, 1'b0, 1, 1'b1, 64'h0, 1'b0);
    applyStimulus(64'h6000_0400, SV39 | (64'd2 << 44), 2'b00, 1'b0, 1, 1'b1, 64'h0, 1'b0);
`endif

    for (int n = 0; n < 250; n++) begin
      vpn = 27'h100 + 27'($urandom_range(0, 15));
      va  = {25'($urandom), vpn, 12'($urandom)};
      s   = ($urandom_range(0, 9) == 0) ? 64'h0 : SV39;
      s[59:44] = 16'($urandom_range(0, 1));
      m   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 1));
      applyStimulus(va, s, m, ($urandom_range(0, 15) == 0), $urandom_range(1, 6),
                    ($urandom_range(0, 4) != 0), {$urandom, $urandom},
                    ($urandom_range(0, 19) == 0));
    end
    drain();

    waitReady();
    va          = {25'h0, 27'h7ABCDE, 12'h345};
    w_lat       = 1000;
    w_ok        = 1'b1;
    w_pa        = '0;
    exp_walk_va = va;
    exp_walks++;
    abort_walk  = 1'b1;
    req_valid   = 1'b1;
    req_va      = va;
    satp        = SV39;
    mmode       = 2'b00;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("walk_en_before_reset", walk_en, 1'b1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_reset_walk_en", walk_en, 1'b0);
    checkOutput("async_reset_req_ready", req_ready, 1'b0);
    checkOutput("async_reset_walk_va", walk_va, 64'h0);
    checkOutput("async_reset_resp_valid", resp_valid, 1'b0);
    model_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    abort_walk = 1'b0;
    checkOutput("ready_after_async_reset", req_ready, 1'b1);
    applyStimulus(64'h4000_0ABC, SV39, 2'b00, 1'b0, 2, 1'b1, 64'h8030_4000, 1'b0);
    applyStimulus(64'h4000_0FFF, SV39, 2'b00, 1'b0, 1, 1'b1, 64'h0, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    checkOutput("walk_count", seen_walks, exp_walks);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
